// File: rtl/lockstep_checker.sv
// lockstep_checker
//   Watches the fetch addresses of two cores running the same program in
//   lockstep. A run of MAX_SKEW consecutive unequal-address cycles is a
//   fault; a nonzero completion flag from data RAM ends the run cleanly; a
//   run lasting TIMEOUT_CYCLES cycles without either is a timeout.
//
// Ports
//   clk_i               clock, rising edge
//   rst_ni              asynchronous active-low reset
//   enable_i            start/hold the check; low returns to IDLE
//   instr_addr1_i/2_i   fetch addresses of core 1 / core 2
//   mem_flag_i          completion flag word, nonzero = program done
//   mem_result_i        result word, captured on entry to DONE
//   state_o             IDLE=0 RUN=1 DONE=2 FAULT=3 TIMEOUT=4
//   done_o/fault_o/timeout_o  high while in the matching terminal state
//   result_o            captured result
//   fault_addr1_o/2_o   addresses captured on entry to FAULT
//   mismatch_count_o    RUN cycles with unequal addresses (saturating)
//   cycle_count_o       RUN cycles elapsed (saturating)
//
// state   | meaning
// IDLE    | waiting for enable_i; counters and captures hold
// RUN     | comparing addresses, counting cycles
// DONE    | program finished, result captured (sticky)
// FAULT   | skew limit reached, addresses captured (sticky)
// TIMEOUT | cycle budget exhausted (sticky)

module lockstep_checker #(
  parameter int unsigned MAX_SKEW       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic [31:0] instr_addr1_i,
  input  logic [31:0] instr_addr2_i,
  input  logic [31:0] mem_flag_i,
  input  logic [31:0] mem_result_i,
  output logic [2:0]  state_o,
  output logic        done_o,
  output logic        fault_o,
  output logic        timeout_o,
  output logic [31:0] result_o,
  output logic [31:0] fault_addr1_o,
  output logic [31:0] fault_addr2_o,
  output logic [15:0] mismatch_count_o,
  output logic [15:0] cycle_count_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_DONE    = 3'd2,
    S_FAULT   = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;

  // Terminal-count compare values: the exit fires in the cycle whose
  // incoming count is one short of the limit.
  localparam logic [7:0]  SKEW_LAST = 8'(MAX_SKEW - 1);
  localparam logic [15:0] CYC_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  skew_q, skew_d;
  logic [15:0] mism_q, mism_d;
  logic [15:0] cyc_q, cyc_d;
  logic [31:0] result_q, result_d;
  logic [31:0] fa1_q, fa1_d;
  logic [31:0] fa2_q, fa2_d;
  logic        done_q, fault_q, timeout_q;
  logic        addr_neq;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      skew_q    <= '0;
      mism_q    <= '0;
      cyc_q     <= '0;
      result_q  <= '0;
      fa1_q     <= '0;
      fa2_q     <= '0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      skew_q    <= skew_d;
      mism_q    <= mism_d;
      cyc_q     <= cyc_d;
      result_q  <= result_d;
      fa1_q     <= fa1_d;
      fa2_q     <= fa2_d;
      // Flags are registered from the next state so they line up with state_o.
      done_q    <= (state_d == S_DONE);
      fault_q   <= (state_d == S_FAULT);
      timeout_q <= (state_d == S_TIMEOUT);
    end
  end

  always_comb begin
    state_d  = state_q;
    skew_d   = skew_q;
    mism_d   = mism_q;
    cyc_d    = cyc_q;
    result_d = result_q;
    fa1_d    = fa1_q;
    fa2_d    = fa2_q;
    addr_neq = (instr_addr1_i != instr_addr2_i);

    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d  = S_RUN;
          skew_d   = '0;
          mism_d   = '0;
          cyc_d    = '0;
          result_d = '0;
          fa1_d    = '0;
          fa2_d    = '0;
        end
      end

      S_RUN: begin
        // Dropping enable wins over every exit and freezes all counters.
        if (!enable_i) begin
          state_d = S_IDLE;
        end else begin
          if (cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;

          if (addr_neq) begin
            skew_d = skew_q + 8'd1;
            if (mism_q != 16'hFFFF) mism_d = mism_q + 16'd1;
          end else begin
            skew_d = '0;
          end

          if (addr_neq && (skew_q == SKEW_LAST)) begin
            state_d = S_FAULT;
            fa1_d   = instr_addr1_i;
            fa2_d   = instr_addr2_i;
          end else if (mem_flag_i != 32'd0) begin
            state_d  = S_DONE;
            result_d = mem_result_i;
          end else if (cyc_q == CYC_LAST) begin
            state_d = S_TIMEOUT;
          end
        end
      end

      S_DONE, S_FAULT, S_TIMEOUT: begin
        if (!enable_i) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign state_o          = state_q;
  assign done_o           = done_q;
  assign fault_o          = fault_q;
  assign timeout_o        = timeout_q;
  assign result_o         = result_q;
  assign fault_addr1_o    = fa1_q;
  assign fault_addr2_o    = fa2_q;
  assign mismatch_count_o = mism_q;
  assign cycle_count_o    = cyc_q;

endmodule

// File: tb/tb_lockstep_checker.sv
module tb_lockstep_checker;

  localparam int MAX_SKEW = 3;
  localparam int TIMEOUT  = 100;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_RUN = 3'd1, ST_DONE = 3'd2,
                         ST_FAULT = 3'd3, ST_TIMEOUT = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] a1, a2, flag, res;

  logic [2:0]  state_o;
  logic        done_o, fault_o, timeout_o;
  logic [31:0] result_o, fault_addr1_o, fault_addr2_o;
  logic [15:0] mismatch_count_o, cycle_count_o;

  int checks   = 0;
  int failures = 0;

  // reference model: run-length view of the rules
  logic [2:0]  m_state;
  int          run_len;
  int unsigned m_mism, m_cyc;
  logic [31:0] m_res, m_fa1, m_fa2;

  always #5 clk = ~clk;

  lockstep_checker #(.MAX_SKEW(MAX_SKEW), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en),
    .instr_addr1_i(a1), .instr_addr2_i(a2),
    .mem_flag_i(flag), .mem_result_i(res),
    .state_o(state_o), .done_o(done_o), .fault_o(fault_o), .timeout_o(timeout_o),
    .result_o(result_o), .fault_addr1_o(fault_addr1_o), .fault_addr2_o(fault_addr2_o),
    .mismatch_count_o(mismatch_count_o), .cycle_count_o(cycle_count_o)
  );

  function automatic void model_reset();
    m_state = ST_IDLE; run_len = 0; m_mism = 0; m_cyc = 0;
    m_res = 0; m_fa1 = 0; m_fa2 = 0;
  endfunction

  function automatic void model_clock();
    bit mis, fault_now, done_now, to_now;
    if (!en) begin
      m_state = ST_IDLE;
      return;
    end
    case (m_state)
      ST_IDLE: begin
        m_state = ST_RUN; run_len = 0; m_mism = 0; m_cyc = 0;
        m_res = 0; m_fa1 = 0; m_fa2 = 0;
      end
      ST_RUN: begin
        mis       = (a1 != a2);
        fault_now = mis && (run_len + 1 >= MAX_SKEW);
        done_now  = (flag != 0);
        to_now    = (m_cyc + 1 == TIMEOUT);
        m_cyc     = (m_cyc < 65535) ? m_cyc + 1 : 65535;
        if (mis) begin
          run_len = run_len + 1;
          m_mism  = (m_mism < 65535) ? m_mism + 1 : 65535;
        end else begin
          run_len = 0;
        end
        if (fault_now) begin
          m_state = ST_FAULT; m_fa1 = a1; m_fa2 = a2;
        end else if (done_now) begin
          m_state = ST_DONE; m_res = res;
        end else if (to_now) begin
          m_state = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic restart();
    en = 1'b0; tick();
    en = 1'b1; tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; a1 = 0; a2 = 0; flag = 0; res = 0;
    model_reset();
    #3;
    checks++;
    if (state_o !== ST_IDLE || {done_o, fault_o, timeout_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_state: state=%0d flags=%b, required state=0 flags=000",
               state_o, {done_o, fault_o, timeout_o});
    end
    checks++;
    if ({result_o, fault_addr1_o, fault_addr2_o, mismatch_count_o, cycle_count_o} !== '0) begin
      failures++;
      $display("FAIL reset_values: res=%h fa1=%h fa2=%h mism=%0d cyc=%0d, required all 0",
               result_o, fault_addr1_o, fault_addr2_o, mismatch_count_o, cycle_count_o);
    end
    en = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (state_o !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_hold: state=%0d, required 0", state_o);
    end
    en = 1'b0; rst_n = 1'b1;
    tick();
    checks++;
    if (state_o !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_release_idle: state=%0d, required 0", state_o);
    end
  endtask

  task automatic test_done();
    en = 1'b1; tick();
    for (int i = 0; i <= 20; i++) begin
      a1 = 32'h1000 + i * 4; a2 = a1;
      flag = (i == 20) ? 32'd1 : 32'd0;
      res  = (i == 20) ? 32'd55 : $urandom;
      tick();
      checks++;
      if (state_o !== m_state) begin
        failures++;
        $display("FAIL done_seq_state cyc%0d: state=%0d, required %0d", i, state_o, m_state);
      end
    end
    flag = 0;
    checks++;
    if (state_o !== ST_DONE || done_o !== 1'b1 || fault_o !== 1'b0 || timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL done_entry: state=%0d d/f/t=%b, required 2 100", state_o, {done_o, fault_o, timeout_o});
    end
    checks++;
    if (result_o !== 32'd55 || mismatch_count_o !== 16'd0 || cycle_count_o !== 16'd21) begin
      failures++;
      $display("FAIL done_values: res=%0d mism=%0d cyc=%0d, required 55 0 21",
               result_o, mismatch_count_o, cycle_count_o);
    end
    a1 = 1; a2 = 2; res = 99; flag = 1;
    tick(); tick();
    checks++;
    if (state_o !== ST_DONE || result_o !== 32'd55 || cycle_count_o !== 16'd21 || mismatch_count_o !== 16'd0) begin
      failures++;
      $display("FAIL done_sticky: state=%0d res=%0d cyc=%0d mism=%0d, required 2 55 21 0",
               state_o, result_o, cycle_count_o, mismatch_count_o);
    end
    flag = 0;
  endtask

  task automatic test_fault();
    logic [31:0] p1 [6];
    logic [31:0] p2 [6];
    p1 = '{32'h10, 32'h14, 32'h18, 32'h20, 32'h24, 32'h80};
    p2 = '{32'h14, 32'h18, 32'h18, 32'h24, 32'h28, 32'h84};
    restart();
    for (int i = 0; i < 6; i++) begin
      a1 = p1[i]; a2 = p2[i]; flag = 0; res = $urandom;
      tick();
      checks++;
      if (state_o !== ((i == 5) ? ST_FAULT : ST_RUN)) begin
        failures++;
        $display("FAIL fault_seq_state cyc%0d: state=%0d, required %0d", i, state_o,
                 (i == 5) ? ST_FAULT : ST_RUN);
      end
    end
    checks++;
    if (fault_o !== 1'b1 || done_o !== 1'b0 || fault_addr1_o !== 32'h80 || fault_addr2_o !== 32'h84) begin
      failures++;
      $display("FAIL fault_capture: fault=%b done=%b fa1=%h fa2=%h, required 1 0 80 84",
               fault_o, done_o, fault_addr1_o, fault_addr2_o);
    end
    checks++;
    if (mismatch_count_o !== 16'd5 || cycle_count_o !== 16'd6) begin
      failures++;
      $display("FAIL fault_counts: mism=%0d cyc=%0d, required 5 6", mismatch_count_o, cycle_count_o);
    end
  endtask

  task automatic test_timeout();
    restart();
    flag = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      a1 = $urandom; a2 = a1;
      tick();
      if (i == TIMEOUT - 2) begin
        checks++;
        if (state_o !== ST_RUN || cycle_count_o !== 16'(TIMEOUT - 1)) begin
          failures++;
          $display("FAIL timeout_early: state=%0d cyc=%0d, required 1 %0d", state_o, cycle_count_o, TIMEOUT - 1);
        end
      end
    end
    checks++;
    if (state_o !== ST_TIMEOUT || timeout_o !== 1'b1 || cycle_count_o !== 16'(TIMEOUT)) begin
      failures++;
      $display("FAIL timeout_entry: state=%0d to=%b cyc=%0d, required 4 1 %0d",
               state_o, timeout_o, cycle_count_o, TIMEOUT);
    end
    tick(); tick();
    checks++;
    if (state_o !== ST_TIMEOUT || cycle_count_o !== 16'(TIMEOUT) || {done_o, fault_o} !== 2'b00) begin
      failures++;
      $display("FAIL timeout_sticky: state=%0d cyc=%0d d/f=%b, required 4 %0d 00",
               state_o, cycle_count_o, {done_o, fault_o}, TIMEOUT);
    end
  endtask

  task automatic test_priority();
    restart();
    for (int i = 0; i < 3; i++) begin
      a1 = 32'h200 + i; a2 = 32'h300 + i;
      flag = (i == 2) ? 32'h1 : 32'h0;
      res  = 32'hDEAD;
      tick();
    end
    flag = 0;
    checks++;
    if (state_o !== ST_FAULT || fault_o !== 1'b1 || done_o !== 1'b0 || result_o !== 32'd0) begin
      failures++;
      $display("FAIL fault_beats_done: state=%0d f=%b d=%b res=%h, required 3 1 0 0",
               state_o, fault_o, done_o, result_o);
    end
    checks++;
    if (fault_addr1_o !== 32'h202 || fault_addr2_o !== 32'h302) begin
      failures++;
      $display("FAIL fault_beats_done_addr: fa1=%h fa2=%h, required 202 302", fault_addr1_o, fault_addr2_o);
    end
    restart();
    for (int i = 0; i < 3; i++) begin
      a1 = 32'h40; a2 = 32'h44;
      if (i == 2) begin en = 1'b0; flag = 1; res = 32'hBEEF; end
      tick();
    end
    flag = 0;
    checks++;
    if (state_o !== ST_IDLE || fault_addr1_o !== 32'd0 || result_o !== 32'd0) begin
      failures++;
      $display("FAIL enable_drop_wins: state=%0d fa1=%h res=%h, required 0 0 0",
               state_o, fault_addr1_o, result_o);
    end
  endtask

  task automatic test_async_reset();
    restart();
    for (int i = 0; i < 4; i++) begin
      a1 = i; a2 = (i == 1) ? 32'h99 : i; flag = 0;
      tick();
    end
    en = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (state_o !== ST_IDLE || cycle_count_o !== 16'd0 || mismatch_count_o !== 16'd0 ||
        {done_o, fault_o, timeout_o} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset: state=%0d cyc=%0d mism=%0d flags=%b, required 0 0 0 000",
               state_o, cycle_count_o, mismatch_count_o, {done_o, fault_o, timeout_o});
    end
    #1 rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (state_o !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_then_idle: state=%0d, required 0", state_o);
    end
    en = 1'b1; tick();
    checks++;
    if (state_o !== ST_RUN || cycle_count_o !== 16'd0) begin
      failures++;
      $display("FAIL restart_after_reset: state=%0d cyc=%0d, required 1 0", state_o, cycle_count_o);
    end
  endtask

  task automatic test_done_reenable();
    logic [31:0] r;
    r = $urandom | 32'h1;
    restart();
    a1 = 8; a2 = 12; flag = 0; tick();
    a2 = 8; flag = 32'h100; res = r; tick();
    flag = 0;
    checks++;
    if (state_o !== ST_DONE || result_o !== r) begin
      failures++;
      $display("FAIL reenable_done: state=%0d res=%h, required 2 %h", state_o, result_o, r);
    end
    en = 1'b0; tick();
    checks++;
    if (state_o !== ST_IDLE || done_o !== 1'b0 || result_o !== r || cycle_count_o !== 16'd2 ||
        mismatch_count_o !== 16'd1) begin
      failures++;
      $display("FAIL idle_holds: state=%0d done=%b res=%h cyc=%0d mism=%0d, required 0 0 %h 2 1",
               state_o, done_o, result_o, cycle_count_o, mismatch_count_o, r);
    end
    en = 1'b1; tick();
    checks++;
    if (state_o !== ST_RUN || result_o !== 32'd0 || cycle_count_o !== 16'd0 || mismatch_count_o !== 16'd0 ||
        fault_addr1_o !== 32'd0 || fault_addr2_o !== 32'd0) begin
      failures++;
      $display("FAIL rerun_cleared: state=%0d res=%h cyc=%0d mism=%0d fa=%h/%h, required 1 0 0 0 0/0",
               state_o, result_o, cycle_count_o, mismatch_count_o, fault_addr1_o, fault_addr2_o);
    end
  endtask

  task automatic test_random();
    int errs;
    logic [2:0] exp_flags;
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 39) != 0);
      a1 = 32'h4000 + 4 * $urandom_range(0, 7);
      if (i < 1500) begin
        a2   = ($urandom_range(0, 2) == 0) ? a1 + 4 : a1;
        flag = ($urandom_range(0, 24) == 0) ? $urandom : 32'd0;
      end else begin
        a2   = ($urandom_range(0, 59) == 0) ? a1 ^ 32'h10 : a1;
        flag = 32'd0;
      end
      res = $urandom;
      tick();
      exp_flags = {m_state == ST_DONE, m_state == ST_FAULT, m_state == ST_TIMEOUT};
      checks++;
      if (state_o !== m_state || {done_o, fault_o, timeout_o} !== exp_flags ||
          result_o !== m_res || fault_addr1_o !== m_fa1 || fault_addr2_o !== m_fa2 ||
          mismatch_count_o !== 16'(m_mism) || cycle_count_o !== 16'(m_cyc)) begin
        failures++;
        if (errs < 10)
          $display("FAIL random cyc%0d: st=%0d fl=%b res=%h fa=%h/%h mism=%0d cyc=%0d, required st=%0d fl=%b res=%h fa=%h/%h mism=%0d cyc=%0d",
                    i, state_o, {done_o, fault_o, timeout_o}, result_o, fault_addr1_o, fault_addr2_o,
                    mismatch_count_o, cycle_count_o, m_state, exp_flags, m_res, m_fa1, m_fa2, m_mism, m_cyc);
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_done();
    test_fault();
    test_timeout();
    test_priority();
    test_async_reset();
    test_done_reenable();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
